trap_filter_mc: RTL and testbench
=================================

Name: trap_filter_mc

Overview:
- Multi-channel, runtime-configurable trapezoidal shaping filter for ADC sample streams. It is the parametrised successor of the single-channel fixed-coefficient shaper.
- Sits between the ADC deserialiser and the peak/energy extraction logic.
- All CH channels share one sample strobe and one configuration.
- Adds valid handshake, runtime k/l/M, a bypass mode, config validation, settled indication and output saturation.

Parameters:
- CH, 4, number of parallel channels
- DATA_W, 12, ADC sample width (unsigned)
- MAX_K, 32, maximum rise length k (samples)
- MAX_L, 64, maximum l (rise+flat top); history depth MAX_K+MAX_L
- M_W, 12, width of unsigned pole-zero multiplier M
- ACC_W, 48, signed width of internal p, r, s accumulators
- OUT_W, 16, signed output width per channel
- SHIFT, 8, arithmetic right shift applied to s before saturation

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  one sample per channel present this cycle
- in_data  in  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W], unsigned
- cfg_load  in  1  1-cycle strobe: apply cfg_* values
- cfg_k  in  $clog2(MAX_K+1)  rise length
- cfg_l  in  $clog2(MAX_L+1)  rise + flat-top length
- cfg_m  in  M_W  pole-zero multiplier
- cfg_bypass  in  1  1 = pass raw samples through the same latency
- cfg_err  out  1  last cfg_load was rejected (sticky until next accepted load or reset)
- out_valid  out  1  out_data valid this cycle
- out_data  out  CH*OUT_W  signed shaped output, same packing as in_data
- out_sat  out  CH  per-channel: out_data was clipped this sample
- out_settled  out  1  at least k+l samples accepted since last clear

Behaviour:
- Reset, all outputs and registers 0: history, p, s, pipeline valid bits, out_*, cfg_err. Active configuration becomes k=1, l=2, M=0, bypass=0.
- Config validity: a load is accepted only when 1<=cfg_k<=MAX_K, cfg_k<=cfg_l<=MAX_L, and cfg_l>=1.
- Rejected load:
  - Old config kept.
  - cfg_err=1 the next cycle.
  - No other state is touched.
- Accepted load:
  - New config takes effect the next cycle.
  - cfg_err cleared.
  - All history, p and s zeroed.
  - In-flight pipeline tokens dropped, so no out_valid for samples accepted before the load.
  - Sample counter cleared.
- cfg_load with in_valid in the same cycle: the load wins and that sample is discarded, whether the load is accepted or rejected.
- Per channel, on each accepted sample v(n), zero-extended and signed:
  - d(n) = v(n) - v(n-k) - v(n-l) + v(n-k-l); history taps before the clear read 0.
  - p(n) = p(n-1) + d(n)
  - r(n) = p(n) + M*d(n)
  - s(n) = s(n-1) + r(n)
  - y = s >>> SHIFT, then saturate to signed OUT_W; out_sat=1 iff clipped.
- Width rules:
  - d is DATA_W+3 bits signed.
  - p, r, s are ACC_W bits with two's-complement wrap and no internal saturation; exact cancellation relies on the wrap.
- Bypass mode: out_data = v zero-extended to OUT_W, no shift, out_sat=0. Accumulators still run.
- Pipeline, 4 stages, one token per accepted sample:
  - S1 history write/taps and d.
  - S2 p and M*d.
  - S3 s.
  - S4 shift/saturate register.
- Latency and throughput:
  - in_valid at edge t gives out_valid high for exactly one cycle after edge t+4.
  - Back-to-back in_valid is sustained at 1 sample/clock.
  - p and s only update on tokens.
  - No backpressure.
- out_data/out_sat hold their last value when out_valid=0.
- History: circular buffer depth MAX_K+MAX_L per channel. The write pointer wraps modulo depth; taps are computed modulo depth.
- out_settled:
  - Counter saturates at MAX_K+MAX_L.
  - Asserted with out_valid of the (k+l)-th accepted sample after a clear, then stays high until the next clear or reset.
- Reset mid-stream: everything cleared at that edge; no out_valid for earlier samples.

Test Plan:
- SHIFT=0, k=4, l=8, M=0; impulse 100 on ch0, others 0 -> ch0 out over 12 valid samples: 100,200,300,400,400,400,400,400,300,200,100,0. Other channels stay 0. First out_valid 4 clocks after the impulse.
- Same config with M=1; same impulse -> 200,300,400,500,400,400,400,400,200,100,0,-100,0.
- SHIFT=0, k=32, l=64, M=0; impulse 4095 -> out saturates at 32767 with out_sat[0]=1 for the plateau samples. Unclipped samples have out_sat=0.
- cfg_load with k=10, l=5 -> cfg_err=1, previous filter response unchanged. A following valid load clears cfg_err and zeroes p/s (out=0 for zero input).
- in_valid gapped (1 of every 3 clocks) -> same output sequence as the contiguous case. out_settled rises on sample k+l.
- Reset asserted for 1 cycle mid-pulse; cfg_load coincident with in_valid -> out_valid=0 for all in-flight samples. The coincident sample is dropped, and config returns to defaults after reset.

Source files
------------

// File: rtl/trap_filter_mc.sv
// trap_filter_mc: multi-channel runtime-configurable trapezoidal shaper with pole-zero correction, bypass and saturation
module trap_filter_mc #(
  parameter int CH = 4,
  parameter int DATA_W = 12,
  parameter int MAX_K = 32,
  parameter int MAX_L = 64,
  parameter int M_W = 12,
  parameter int ACC_W = 48,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [CH*DATA_W-1:0]         in_data,
  input  logic                         cfg_load,
  input  logic [$clog2(MAX_K+1)-1:0]   cfg_k,
  input  logic [$clog2(MAX_L+1)-1:0]   cfg_l,
  input  logic [M_W-1:0]               cfg_m,
  input  logic                         cfg_bypass,
  output logic                         cfg_err,
  output logic                         out_valid,
  output logic [CH*OUT_W-1:0]          out_data,
  output logic [CH-1:0]                out_sat,
  output logic                         out_settled
);
  localparam int D = MAX_K + MAX_L;
  localparam int PW = $clog2(D);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int LW = $clog2(MAX_L + 1);
  localparam int CW = $clog2(D + 1);
  localparam int DX = DATA_W + 3;
  localparam logic [PW:0] DEPTH = (PW+1)'(D);
  localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic [KW-1:0] k;
  logic [LW-1:0] l;
  logic [M_W-1:0] m;
  logic bypass;
  logic [PW-1:0] wp, ik, il, ikl;
  logic [CW-1:0] cnt;
  logic cfg_ok, take, clr, settle_n;
  logic v1, v2, v3, f1, f2, f3;
  logic [DATA_W-1:0] hist [CH][D];
  logic [DATA_W-1:0] x1 [CH];
  logic [DATA_W-1:0] x2 [CH];
  logic [DATA_W-1:0] x3 [CH];
  logic signed [DX-1:0] d_n [CH];
  logic signed [DX-1:0] d1 [CH];
  logic signed [ACC_W-1:0] p [CH];
  logic signed [ACC_W-1:0] md [CH];
  logic signed [ACC_W-1:0] s [CH];
  logic signed [ACC_W-1:0] y [CH];
  logic [CH*OUT_W-1:0] data_n;
  logic [CH-1:0] sat_n;

  function automatic logic [PW-1:0] tap(input logic [PW-1:0] ptr, input logic [PW:0] off);
    logic [PW:0] t;
    t = {1'b0, ptr} + DEPTH - off;
    return t >= DEPTH ? PW'(t - DEPTH) : PW'(t);
  endfunction

  function automatic logic signed [DX-1:0] ze(input logic [DATA_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [DX-1:0] v);
    return {{(ACC_W-DX){v[DX-1]}}, v};
  endfunction

  always_comb begin
    cfg_ok = cfg_k != '0 && cfg_k <= KW'(MAX_K) && LW'(cfg_k) <= cfg_l && cfg_l <= LW'(MAX_L);
    take = in_valid && !cfg_load;
    clr = cfg_load && cfg_ok;
    ik = tap(wp, (PW+1)'(k));
    il = tap(wp, (PW+1)'(l));
    ikl = tap(wp, (PW+1)'(k) + (PW+1)'(l));
    settle_n = (CW+1)'(cnt) + 1'b1 >= (CW+1)'(k) + (CW+1)'(l);
    d_n = '{default: '0};
    y = '{default: '0};
    data_n = '0;
    sat_n = '0;
    for (int c = 0; c < CH; c++) begin
      d_n[c] = ze(in_data[c*DATA_W +: DATA_W]) - ze(hist[c][ik]) - ze(hist[c][il]) + ze(hist[c][ikl]);
      y[c] = s[c] >>> SHIFT;
      sat_n[c] = !bypass && (y[c] > HI || y[c] < LO);
      data_n[c*OUT_W +: OUT_W] = bypass ? OUT_W'(x3[c]) : y[c] > HI ? HI[OUT_W-1:0] :
                                 y[c] < LO ? LO[OUT_W-1:0] : y[c][OUT_W-1:0];
    end
  end

  always_ff @(posedge clk)
    if (reset) begin
      k <= KW'(1);
      l <= LW'(2);
      m <= '0;
      bypass <= 1'b0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      cfg_err <= !cfg_ok;
      if (cfg_ok) begin
        k <= cfg_k;
        l <= cfg_l;
        m <= cfg_m;
        bypass <= cfg_bypass;
      end
    end

  // p and s wrap freely; the trapezoid returns them to zero by exact cancellation
  always_ff @(posedge clk)
    if (reset || clr) begin
      wp <= '0;
      cnt <= '0;
      {v1, v2, v3, f1, f2, f3, out_valid, out_settled} <= '0;
      for (int c = 0; c < CH; c++) begin
        p[c] <= '0;
        md[c] <= '0;
        s[c] <= '0;
        d1[c] <= '0;
        x1[c] <= '0;
        x2[c] <= '0;
        x3[c] <= '0;
        for (int i = 0; i < D; i++) hist[c][i] <= '0;
      end
    end else begin
      {v1, v2, v3, out_valid} <= {take, v1, v2, v3};
      if (take) begin
        wp <= wp == PW'(D - 1) ? '0 : wp + 1'b1;
        cnt <= cnt == CW'(D) ? cnt : cnt + 1'b1;
        f1 <= settle_n;
      end
      if (v1) f2 <= f1;
      if (v2) f3 <= f2;
      if (v3 && f3) out_settled <= 1'b1;
      for (int c = 0; c < CH; c++) begin
        if (take) begin
          hist[c][wp] <= in_data[c*DATA_W +: DATA_W];
          d1[c] <= d_n[c];
          x1[c] <= in_data[c*DATA_W +: DATA_W];
        end
        if (v1) begin
          p[c] <= p[c] + sx(d1[c]);
          md[c] <= sx(d1[c]) * {{(ACC_W-M_W){1'b0}}, m};
          x2[c] <= x1[c];
        end
        if (v2) begin
          s[c] <= s[c] + p[c] + md[c];
          x3[c] <= x2[c];
        end
      end
    end

  always_ff @(posedge clk)
    if (reset) begin
      out_data <= '0;
      out_sat <= '0;
    end else if (v3 && !clr) begin
      out_data <= data_n;
      out_sat <= sat_n;
    end
endmodule

// File: tb/tb_trap_filter_mc.sv
// tb_trap_filter_mc: directed checks of the trapezoidal shaper with SHIFT=0
module tb_trap_filter_mc;
  localparam int CH = 4, DW = 12, OW = 16;
  logic clk = 1'b0;
  logic reset, in_valid, cfg_load, cfg_bypass, cfg_err, out_valid, out_settled;
  logic [CH*DW-1:0] in_data;
  logic [5:0] cfg_k;
  logic [6:0] cfg_l;
  logic [11:0] cfg_m;
  logic [CH*OW-1:0] out_data;
  logic [CH-1:0] out_sat;
  int checks = 0, failures = 0, lat;
  int q0[$];
  int qsat[$];
  int qset[$];
  int qoth[$];
  logic [CH*OW-1:0] qall[$];
  int e_m0[13] = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0};
  int e_m1[13] = '{200, 300, 400, 500, 400, 400, 400, 400, 200, 100, 0, -100, 0};

  always #5 clk = ~clk;

  trap_filter_mc #(.SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_bypass(cfg_bypass),
    .cfg_err(cfg_err), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
    .out_settled(out_settled)
  );

  always @(negedge clk)
    if (out_valid) begin
      q0.push_back(int'($signed(out_data[OW-1:0])));
      qsat.push_back(int'(out_sat[0]));
      qset.push_back(int'(out_settled));
      qoth.push_back(int'(out_data[CH*OW-1:OW] != '0 || out_sat[CH-1:1] != '0));
      qall.push_back(out_data);
    end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clrq();
    q0.delete(); qsat.delete(); qset.delete(); qoth.delete(); qall.delete();
  endtask

  task automatic push(input logic [CH*DW-1:0] x);
    in_valid = 1'b1;
    in_data = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int l, input int m, input logic b);
    cfg_load = 1'b1;
    cfg_k = 6'(k);
    cfg_l = 7'(l);
    cfg_m = 12'(m);
    cfg_bypass = b;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic default_resp(input string tag);
    clrq();
    push(48'd100);
    repeat (5) push(48'd0);
    idle(6);
    chk({tag, "_n"}, q0.size(), 6);
    chk({tag, "_0"}, q0[0], 100);
    chk({tag, "_1"}, q0[1], 100);
    chk({tag, "_2"}, q0[2], 0);
    chk({tag, "_3"}, q0[3], 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_load = 1'b0;
    cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", int'(out_data != '0), 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_settled", out_settled, 0);
    reset = 1'b0;
    idle(1);
    default_resp("dflt");
    // k=4 l=8 M=0: latency and impulse response
    load(4, 8, 0, 1'b0);
    chk("load_err", cfg_err, 0);
    clrq();
    push(48'd100);
    lat = 1;
    while (!out_valid && lat < 10) begin
      push(48'd0);
      lat++;
    end
    chk("latency", lat, 4);
    repeat (12) push(48'd0);
    idle(6);
    chk("m0_n", q0.size(), 16);
    for (int i = 0; i < 13; i++) chk($sformatf("m0_%0d", i), q0[i], e_m0[i]);
    for (int i = 0; i < 16; i++) chk($sformatf("m0_oth_%0d", i), qoth[i], 0);
    for (int i = 0; i < 16; i++) chk($sformatf("m0_sat_%0d", i), qsat[i], 0);
    // M=1 contiguous
    load(4, 8, 1, 1'b0);
    clrq();
    push(48'd100);
    repeat (15) push(48'd0);
    idle(6);
    chk("m1_n", q0.size(), 16);
    for (int i = 0; i < 13; i++) chk($sformatf("m1_%0d", i), q0[i], e_m1[i]);
    // M=1 gapped, settle rises on sample 12
    load(4, 8, 1, 1'b0);
    clrq();
    for (int i = 0; i < 16; i++) begin
      push(i == 0 ? 48'd100 : 48'd0);
      idle(2);
    end
    idle(6);
    chk("gap_n", q0.size(), 16);
    for (int i = 0; i < 13; i++) chk($sformatf("gap_%0d", i), q0[i], e_m1[i]);
    chk("settle_10", qset[10], 0);
    chk("settle_11", qset[11], 1);
    chk("settle_hold", out_settled, 1);
    // rejected load keeps the M=1 filter
    load(10, 5, 0, 1'b0);
    chk("rej_err", cfg_err, 1);
    clrq();
    push(48'd100);
    repeat (15) push(48'd0);
    idle(6);
    chk("rej_n", q0.size(), 16);
    for (int i = 0; i < 13; i++) chk($sformatf("rej_%0d", i), q0[i], e_m1[i]);
    chk("rej_err_sticky", cfg_err, 1);
    // accepted load mid-pulse drops tokens and zeroes state
    clrq();
    push(48'd100);
    push(48'd0);
    push(48'd0);
    load(4, 8, 0, 1'b0);
    chk("clr_err", cfg_err, 0);
    repeat (8) push(48'd0);
    idle(6);
    chk("clr_n", q0.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("clr_%0d", i), q0[i], 0);
    chk("clr_settled", out_settled, 0);
    // full-size window with saturation
    load(32, 64, 0, 1'b0);
    clrq();
    push(48'd4095);
    repeat (99) push(48'd0);
    idle(6);
    chk("sat_n", q0.size(), 100);
    chk("sat_v0", q0[0], 4095);
    chk("sat_s0", qsat[0], 0);
    chk("sat_v7", q0[7], 32760);
    chk("sat_s7", qsat[7], 0);
    chk("sat_v8", q0[8], 32767);
    chk("sat_s8", qsat[8], 1);
    chk("sat_v40", q0[40], 32767);
    chk("sat_s40", qsat[40], 1);
    chk("sat_v86", q0[86], 32767);
    chk("sat_s86", qsat[86], 1);
    chk("sat_v87", q0[87], 32760);
    chk("sat_s87", qsat[87], 0);
    chk("sat_v95", q0[95], 0);
    chk("sat_v97", q0[97], 0);
    chk("sat_settle_94", qset[94], 0);
    chk("sat_settle_95", qset[95], 1);
    // bypass passes raw samples on every channel and holds them
    load(4, 8, 0, 1'b1);
    clrq();
    push({12'd4095, 12'd7, 12'd300, 12'd100});
    push({12'd1, 12'd2, 12'd3, 12'd4000});
    idle(6);
    chk("byp_n", q0.size(), 2);
    chk("byp_0", int'(qall[0] == {16'd4095, 16'd7, 16'd300, 16'd100}), 1);
    chk("byp_1", int'(qall[1] == {16'd1, 16'd2, 16'd3, 16'd4000}), 1);
    chk("byp_sat", qsat[0] + qsat[1] + qoth[0] - 1, 0);
    chk("byp_hold", int'(out_data == {16'd1, 16'd2, 16'd3, 16'd4000}), 1);
    // reset mid-pulse drops in-flight samples and restores defaults
    load(4, 8, 0, 1'b0);
    load(10, 5, 0, 1'b0);
    clrq();
    push(48'd100);
    push(48'd0);
    push(48'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(8);
    chk("mrst_n", q0.size(), 0);
    chk("mrst_err", cfg_err, 0);
    chk("mrst_data", int'(out_data != '0), 0);
    default_resp("mrst_dflt");
    // coincident accepted load drops the sample
    load(4, 8, 0, 1'b0);
    clrq();
    in_valid = 1'b1;
    in_data = 48'd100;
    load(4, 8, 0, 1'b0);
    in_valid = 1'b0;
    repeat (14) push(48'd0);
    idle(6);
    chk("coin_n", q0.size(), 14);
    for (int i = 0; i < 14; i++) chk($sformatf("coin_%0d", i), q0[i], 0);
    // coincident rejected load also drops the sample
    clrq();
    in_valid = 1'b1;
    in_data = 48'd100;
    load(0, 8, 0, 1'b0);
    in_valid = 1'b0;
    chk("coin_rej_err", cfg_err, 1);
    repeat (3) push(48'd0);
    idle(6);
    chk("coin_rej_n", q0.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("coin_rej_%0d", i), q0[i], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
